// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
// Shared NES cartridge definitions used by the loader and the game dumper:
// the iNES magic, the SDRAM placement of CHR bank 0, the bank size exponents,
// the dumper FSM state encoding and the iNES flag byte builders.
// -----------------------------------------------------------------------------
package nes_pkg;

  localparam logic [31:0] INES_MAGIC    = 32'h4E45531A;  // "NES" + 0x1A
  localparam logic [21:0] CHR_BASE      = 22'h200000;    // loader places CHR here
  localparam int          PRG_UNIT_LOG2 = 14;            // 16 KiB PRG banks
  localparam int          CHR_UNIT_LOG2 = 13;            // 8 KiB CHR banks

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND,
    ST_DONE
  } dumper_state_t;

  // Flags 6: low mapper nibble on top, mirroring in bit 0.
  function automatic logic [7:0] ines_flags6(input logic [3:0] mapper_lo,
                                             input logic       mirroring);
    return {mapper_lo, 3'b000, mirroring};
  endfunction

  // Flags 7: high mapper nibble on top, everything else clear.
  function automatic logic [7:0] ines_flags7(input logic [3:0] mapper_hi);
    return {mapper_hi, 4'b0000};
  endfunction

endpackage

// File: rtl/ines_header_rom.sv
// -----------------------------------------------------------------------------
// ines_header_rom
// Combinational 16-entry iNES header byte select.
// Ports:
//   i_idx        header byte index 0..15
//   i_prg_banks  PRG size in 16 KiB units
//   i_chr_banks  CHR size in 8 KiB units
//   i_mapper     iNES mapper number
//   i_mirroring  flags6 bit 0
//   o_byte       header byte at i_idx
// -----------------------------------------------------------------------------
module ines_header_rom
  import nes_pkg::*;
(
  input  logic [3:0] i_idx,
  input  logic [7:0] i_prg_banks,
  input  logic [7:0] i_chr_banks,
  input  logic [7:0] i_mapper,
  input  logic       i_mirroring,
  output logic [7:0] o_byte
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    o_byte = 8'h00;
    unique case (i_idx)
      4'd0:    o_byte = INES_MAGIC[31:24];
      4'd1:    o_byte = INES_MAGIC[23:16];
      4'd2:    o_byte = INES_MAGIC[15:8];
      4'd3:    o_byte = INES_MAGIC[7:0];
      4'd4:    o_byte = i_prg_banks;
      4'd5:    o_byte = i_chr_banks;
      4'd6:    o_byte = ines_flags6(i_mapper[3:0], i_mirroring);
      4'd7:    o_byte = ines_flags7(i_mapper[7:4]);
      default: o_byte = 8'h00;  // bytes 8..15 are padding
    endcase
  end

endmodule

// File: rtl/game_dumper.sv
// -----------------------------------------------------------------------------
// game_dumper
// Streams the loaded game image out of SDRAM as an iNES file: 16-byte header,
// then PRG bytes, then CHR bytes, one byte read per stream byte.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               begin a dump (accepted in IDLE or DONE only)
//   prg_banks/chr_banks image sizes, sampled at start
//   mapper/mirroring    iNES header fields, sampled at start
//   mem_addr/mem_read   SDRAM byte read request (level, held until mem_valid)
//   mem_data/mem_valid  SDRAM read return
//   out_data/out_valid  byte stream toward the OSD co-CPU
//   out_ready           consumer accept
//   busy/done           dump in progress / dump finished
// -----------------------------------------------------------------------------
module game_dumper #(
  parameter logic [21:0] CHR_BASE      = nes_pkg::CHR_BASE,
  parameter int          PRG_UNIT_LOG2 = nes_pkg::PRG_UNIT_LOG2,
  parameter int          CHR_UNIT_LOG2 = nes_pkg::CHR_UNIT_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prg_banks,
  input  logic [7:0]  chr_banks,
  input  logic [7:0]  mapper,
  input  logic        mirroring,
  output logic [21:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  mem_data,
  input  logic        mem_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  import nes_pkg::*;

  dumper_state_t r_state, w_next;

  logic [7:0]  r_prg, r_chr, r_mapper;
  logic        r_mirror;
  logic [3:0]  r_hdr_idx;
  logic        r_sec;        // 0 = PRG section, 1 = CHR section
  logic [21:0] r_addr;
  logic [21:0] r_left;       // bytes remaining in the current section
  logic [7:0]  r_data;

  logic        w_hs;
  logic        w_enter;      // leaving HDR or a data byte: evaluate section entry
  logic        w_switch;     // PRG exhausted, move to CHR
  logic [21:0] w_left_after;
  logic [21:0] w_chr_left;
  logic [7:0]  w_hdr_byte;

  ines_header_rom u_hdr (
    .i_idx       (r_hdr_idx),
    .i_prg_banks (r_prg),
    .i_chr_banks (r_chr),
    .i_mapper    (r_mapper),
    .i_mirroring (r_mirror),
    .o_byte      (w_hdr_byte)
  );

  assign w_hs         = out_valid & out_ready;
  assign w_enter      = ((r_state == ST_HDR) && w_hs && (r_hdr_idx == 4'd15)) ||
                        ((r_state == ST_SEND) && w_hs);
  assign w_left_after = (r_state == ST_SEND) ? r_left - 22'd1 : r_left;
  assign w_chr_left   = 22'(r_chr) << CHR_UNIT_LOG2;
  assign w_switch     = w_enter && (w_left_after == 22'd0) && !r_sec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Section entry is resolved in one step: an empty PRG section falls straight
  // through to the CHR size check, so both empty sections end up in DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_HDR;
      ST_HDR, ST_SEND: begin
        if (w_enter) begin
          if (w_left_after != 22'd0)              w_next = ST_RD_REQ;
          else if (w_switch && w_chr_left != 22'd0) w_next = ST_RD_REQ;
          else                                     w_next = ST_DONE;
        end
      end
      ST_RD_REQ:  w_next = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_valid) w_next = ST_SEND;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = r_addr;
    mem_read  = (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT);
    out_valid = (r_state == ST_HDR) || (r_state == ST_SEND);
    busy      = out_valid || mem_read;
    done      = (r_state == ST_DONE);
    out_data  = 8'h00;
    if (r_state == ST_HDR)       out_data = w_hdr_byte;
    else if (r_state == ST_SEND) out_data = r_data;
  end

  // NOTE: the shadow registers are reset along with the counters so that the
  // header and address outputs are fully defined straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prg     <= '0;
      r_chr     <= '0;
      r_mapper  <= '0;
      r_mirror  <= 1'b0;
      r_hdr_idx <= '0;
      r_sec     <= 1'b0;
      r_addr    <= '0;
      r_left    <= '0;
      r_data    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_prg     <= prg_banks;
            r_chr     <= chr_banks;
            r_mapper  <= mapper;
            r_mirror  <= mirroring;
            r_hdr_idx <= '0;
            r_sec     <= 1'b0;
            r_addr    <= '0;
            r_left    <= 22'(prg_banks) << PRG_UNIT_LOG2;
          end
        end
        ST_HDR:     if (w_hs) r_hdr_idx <= r_hdr_idx + 4'd1;
        ST_RD_WAIT: if (mem_valid) r_data <= mem_data;
        ST_SEND:    if (w_hs) r_addr <= r_addr + 22'd1;  // wraps modulo 2^22
        default: ;
      endcase
      // A section switch overrides the address increment above.
      if (w_enter) begin
        if (w_switch) begin
          r_sec  <= 1'b1;
          r_addr <= CHR_BASE;
          r_left <= w_chr_left;
        end else begin
          r_left <= w_left_after;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_dumper.sv
// -----------------------------------------------------------------------------
// tb_game_dumper
// Drives game_dumper with reduced bank sizes (128-byte PRG, 64-byte CHR banks)
// against a memory model whose data is a function of address, and compares
// the captured stream with an iNES image built from the file format rules.
// -----------------------------------------------------------------------------
module tb_game_dumper;

  localparam int          PU = 7;
  localparam int          CU = 6;
  localparam logic [21:0] CB = 22'h200000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  prg_banks = '0, chr_banks = '0, mapper = '0;
  logic        mirroring = 1'b0;
  logic [21:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done;

  game_dumper #(.CHR_BASE(CB), .PRG_UNIT_LOG2(PU), .CHR_UNIT_LOG2(CU)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .mapper(mapper), .mirroring(mirroring),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data), .mem_valid(mem_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int         lat = 2;         // cycles from request to acknowledge
  bit         stall_mode = 1'b0;
  bit         spur = 1'b0;     // spurious mem_valid while no read is pending
  int         n_reads = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  bit          rd_active = 1'b0;
  logic [21:0] held_addr = '0;
  int          wcnt = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_fn(input logic [21:0] a);
    return a[7:0] + (a[15:8] * 8'd3) + (a[21:14] * 8'd7);
  endfunction

  // The iNES image the dump should produce, from the file format itself.
  task automatic build_expected(input logic [7:0] prg, input logic [7:0] chr,
                                input logic [7:0] map, input logic mir);
    exp_q.delete();
    exp_q.push_back(8'h4E); exp_q.push_back(8'h45);
    exp_q.push_back(8'h53); exp_q.push_back(8'h1A);
    exp_q.push_back(prg);   exp_q.push_back(chr);
    exp_q.push_back({map[3:0], 3'b000, mir});
    exp_q.push_back({map[7:4], 4'b0000});
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < int'(prg) * (1 << PU); i++) exp_q.push_back(mem_fn(22'(i)));
    for (int i = 0; i < int'(chr) * (1 << CU); i++) exp_q.push_back(mem_fn(CB + 22'(i)));
  endtask

  // Memory model: acknowledges a held request after lat cycles.
  initial forever begin
    @(negedge clk);
    if (mem_read) begin
      if (rd_active) check("rd_addr_stable", 32'(mem_addr), 32'(held_addr));
      else begin
        rd_active = 1'b1;
        held_addr = mem_addr;
        wcnt      = 0;
        n_reads++;
      end
      wcnt++;
      if (wcnt >= lat) begin
        mem_valid = 1'b1;
        mem_data  = mem_fn(mem_addr);
      end else begin
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
      end
    end else begin
      rd_active = 1'b0;
      mem_valid = spur;
      mem_data  = 8'($urandom);
    end
  end

  // Stream consumer: optional random back-pressure, collects accepted bytes.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
      out_ready  = 1'b1;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data_held", 32'(out_data), 32'(prev_data));
      end
      if (mem_read) check("no_valid_while_reading", 32'(out_valid), 32'd0);
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) rx.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic launch(input logic [7:0] prg, input logic [7:0] chr,
                        input logic [7:0] map, input logic mir);
    build_expected(prg, chr, map, mir);
    rx.delete();
    n_reads = 0;
    @(posedge clk); #2;
    prg_banks = prg; chr_banks = chr; mapper = map; mirroring = mir;
    start = 1'b1;
    @(posedge clk); #1;
    check("first_hdr_valid", 32'(out_valid), 32'd1);
    check("first_hdr_byte", 32'(out_data), 32'h4E);
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    #1;
    start = 1'b0;
    // Size/mapper inputs changing mid-dump must not matter.
    prg_banks = 8'($urandom); chr_banks = 8'($urandom);
    mapper = 8'($urandom); mirroring = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int budget = exp_q.size() * (lat + 3) * 4 + 100;
    int i = 0;
    while (!done && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check({tag, "_done_in_time"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_bytes(input int n);
    int i = 0;
    while (rx.size() < n && i < n * 40) begin
      @(posedge clk); #1;
      i++;
    end
    check("reach_byte_count", 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int bad = -1;
    int n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    check({tag, "_length"}, 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++)
      if (bad < 0 && rx[i] !== exp_q[i]) bad = i;
    check({tag, "_first_bad_index"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  task automatic dump(input string tag, input logic [7:0] prg, input logic [7:0] chr,
                      input logic [7:0] map, input logic mir);
    launch(prg, chr, map, mir);
    wait_done(tag);
    compare_stream(tag);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    #1 reset = 1'b0;

    // Basic PRG+CHR dump, always ready, 2-cycle memory.
    lat = 2;
    dump("basic", 8'd1, 8'd1, 8'h42, 1'b1);
    check("basic_reads", 32'(n_reads), 32'(1 * 128 + 1 * 64));

    // CHR RAM: PRG bytes only.
    dump("chr_ram", 8'd2, 8'd0, 8'h05, 1'b0);
    if (rx.size() > 5) check("chr_ram_hdr5", 32'(rx[5]), 32'd0);
    check("chr_ram_reads", 32'(n_reads), 32'(2 * 128));

    // Random back-pressure.
    stall_mode = 1'b1;
    lat = 3;
    dump("stall", 8'd1, 8'd2, 8'($urandom), 1'($urandom));
    stall_mode = 1'b0;

    // Slow memory plus a spurious acknowledge during the header.
    lat = 20;
    launch(8'd1, 8'd0, 8'h13, 1'b1);
    #1 spur = 1'b1;
    @(posedge clk); #2 spur = 1'b0;
    wait_done("slow_mem");
    compare_stream("slow_mem");
    lat = 2;

    // Reset in the middle of the PRG data, then a clean restart.
    launch(8'd3, 8'd1, 8'h21, 1'b0);
    wait_bytes(16 + 100);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    #1 reset = 1'b0;
    dump("after_rst", 8'd3, 8'd1, 8'h21, 1'b0);

    // Start while busy is ignored; start in DONE relaunches an identical dump.
    launch(8'd1, 8'd1, 8'hA7, 1'b1);
    wait_bytes(40);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("busy_start");
    compare_stream("busy_start");
    dump("relaunch", 8'd1, 8'd1, 8'hA7, 1'b1);

    // Both sections empty: header only.
    dump("empty", 8'd0, 8'd0, 8'hFF, 1'b0);
    check("empty_reads", 32'(n_reads), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
